// File: rtl/mult_pkg.sv
// mult_pkg: shared widths and FSM state encoding for the sequential 4x4 multiplier.
package mult_pkg;
  localparam int OP_W = 4;
  localparam int PROD_W = 8;
  localparam int CNT_W = 2;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
endpackage

// File: rtl/zero_extend.sv
// zero_extend: widens a 4-bit operand to the 8-bit product width.
module zero_extend
  import mult_pkg::*;
(
  input  logic [OP_W-1:0]   a,
  output logic [PROD_W-1:0] y
);
  assign y = {{(PROD_W-OP_W){1'b0}}, a};
endmodule

// File: rtl/mult_seq_ctrl.sv
// mult_seq_ctrl: shift-add sequencer for the 4x4 unsigned multiplier with busy/done handshake.
// Optional MULT_EARLY_EXIT_EN ends iteration once the remaining multiplier bits are zero.
module mult_seq_ctrl
  import mult_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  output logic              busy,
  output logic              done,
  output logic [PROD_W-1:0] product
);
  state_t              state;
  logic [PROD_W-1:0]   acc;
  logic [PROD_W-1:0]   mcand;
  logic [PROD_W-1:0]   a_ext;
  logic [PROD_W-1:0]   acc_nxt;
  logic [OP_W-1:0]     mplier;
  logic [CNT_W-1:0]    cnt;
  logic                last;
  zero_extend u_ext (.a(a), .y(a_ext));
  always_comb acc_nxt = mplier[0] ? acc + mcand : acc;
`ifdef MULT_EARLY_EXIT_EN
  // the shifted multiplier is mplier >> 1, so its upper bits decide an early finish
  always_comb last = (&cnt) || (mplier[OP_W-1:1] == '0);
`else
  always_comb last = &cnt;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          mcand  <= a_ext;
          mplier <= b;
          acc    <= '0;
          cnt    <= '0;
          busy   <= 1'b1;
          state  <= CALC;
        end
        CALC: begin
          acc    <= acc_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (last) begin
            product <= acc_nxt;
            done    <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/mult_seq_ctrl.md
# mult_seq_ctrl

Sequential shift-add controller for the 4x4 unsigned multiplier. It accepts a start request with two 4-bit operands and zero-extends the multiplicand to 8 bits through the existing `zero_extend` block. It then runs four add/shift iterations and presents the 8-bit product with a one-cycle `done` pulse. It sits between the requesting logic and the multiplier datapath and owns all sequencing and handshake state.

## Interface
- Parameters: none. Widths are fixed at 4-bit operands and an 8-bit product, matching the `zero_extend` datapath.
- `clk`  in  1  single clock; all state updates on rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `start`  in  1  request; sampled only in IDLE
- `a`  in  4  multiplicand; captured on the accepting edge
- `b`  in  4  multiplier; captured on the accepting edge
- `busy`  out  1  high whenever state is not IDLE
- `done`  out  1  one-cycle pulse; product valid
- `product`  out  8  registered result; held until the next accepted start

## Operation
- States:
  - IDLE: waiting for `start`.
  - CALC: iterating add/shift.
  - DONE: presenting the result.
- IDLE, `start`=1 on an edge:
  - Load `mcand` = zero_extend(`a`) (8 bits).
  - Load `mplier` = `b`.
  - Clear `acc` (8 bits) and `cnt` (2 bits).
  - Go to CALC.
- IDLE, `start`=0: stay in IDLE; all registers hold.
- CALC, each edge:
  - If `mplier[0]`: `acc` <= `acc` + `mcand`, mod 2^8. Overflow cannot occur for 4x4 operands.
  - `mcand` <= `mcand` << 1 (bit 7 dropped).
  - `mplier` <= `mplier` >> 1 (zero fill).
  - `cnt` <= `cnt` + 1.
  - Leave CALC on the edge where `cnt`==3: go to DONE and load `product` with the final `acc` value, including that edge's add.
- DONE: `done`=1 for exactly one cycle; next edge goes to IDLE unconditionally.
- `start` is ignored while `busy`=1, including in DONE. It is never queued.
- Operand inputs are don't-care outside the accepting edge.
- `start` held high continuously gives back-to-back operations: accepted on the first IDLE edge after DONE.

## Timing
- Reset values:
  - `busy`=0, `done`=0, `product`=8'h00.
  - State IDLE.
  - `acc`, `mcand`, `mplier`, `cnt` all zero.
- Reset asserted mid-CALC or in DONE:
  - Immediate (asynchronous) return to reset values.
  - No `done` pulse; the partial result is discarded.
- Latency, accept on edge k:
  - `busy` high after edge k.
  - CALC occupies edges k+1..k+4.
  - `done`=1 and `product` valid after edge k+4.
  - IDLE after edge k+5.
  - Earliest next accept is edge k+6, so throughput is one product per 6 cycles.
- `done` and `product` are registered outputs; no combinational path from any input to any output.

## Configuration
- `MULT_EARLY_EXIT_EN` defined:
  - In CALC, also transition to DONE on any edge where the shifted `mplier` becomes zero.
  - At least one CALC cycle always executes.
  - Example: `b`=4'b0001 gives `done` after edge k+1.
  - `product` is identical to full iteration in every case.
- `MULT_EARLY_EXIT_EN` undefined: always exactly four CALC cycles; latency is fixed as stated in Timing.

## Structure
- Shared package `mult_pkg`:
  - State enum typedef (IDLE, CALC, DONE).
  - `OP_W`=4, `PROD_W`=8, `CNT_W`=2.
- Sub-module: one instance of the existing `zero_extend` (4->8) feeds the `mcand` load mux.
- FSM, counter and datapath registers stay in `mult_seq_ctrl`.

## Test plan
- `a`=15, `b`=15, single start pulse -> `done` after edge k+4, `product`=225 (8'hE1), `busy` low after k+5.
- `a`=9, `b`=0 with `MULT_EARLY_EXIT_EN` -> `product`=0, `done` after k+1. Same stimulus without the macro -> `done` after k+4.
- Start pulse with `a`=6, `b`=5, then `start`=1 with `a`=3, `b`=3 on edges k+2 and k+5 -> second request ignored, `product`=30.
- `start` held high with `a`=7, `b`=11 -> `product`=77 with `done` pulses at k+4 and k+10. Two pulses observed.
- `rst_n` low for one cycle mid-CALC (after k+2) -> outputs immediately zero, no `done` pulse. A fresh `a`=4, `b`=12 request then yields 48.
- Exhaustive sweep of all 256 operand pairs in both configurations -> `product` = `a`*`b` every time.
